ibex_rvfi_trace_buf: RTL
========================

# ibex_rvfi_trace_buf

Parametrised on-chip trace capture buffer that sits beside the ibex core, in place of the simulation-only text tracer. It samples the core's RVFI retirement port, filters retired instructions by trap/interrupt status and PC range, and stamps each kept record with a cycle timestamp. Kept records are stored in a circular FIFO and drained by a debug or host agent over a valid/ready interface. The FIFO runs in stop-on-full or wrap (overwrite-oldest) mode, and a saturating counter records dropped records.

## Interface
- Depth, 16: FIFO entries; power of two, ≥ 2.
- PcFilterEn, 1'b1: enables the PC range filter; when 0, `cfg_pc_lo_i` and `cfg_pc_hi_i` are ignored.
- TimeWidth, 16: timestamp counter width, 8..32.
- DropWidth, 16: drop counter width, 4..32.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cfg_en_i  in  1  capture enable.
- cfg_wrap_i  in  1  0 = stop-on-full, 1 = overwrite oldest.
- cfg_trap_only_i  in  1  keep only records with rvfi_trap_i or rvfi_intr_i set.
- cfg_pc_lo_i  in  32  inclusive lower PC bound.
- cfg_pc_hi_i  in  32  inclusive upper PC bound.
- flush_i  in  1  empty the FIFO and clear the drop counter.
- rvfi_valid_i  in  1  instruction retired this cycle.
- rvfi_pc_rdata_i  in  32  PC of the retired instruction.
- rvfi_insn_i  in  32  instruction word.
- rvfi_rd_addr_i  in  5  destination register.
- rvfi_rd_wdata_i  in  32  destination write data.
- rvfi_trap_i  in  1  trap flag.
- rvfi_intr_i  in  1  first instruction of a handler.
- rvfi_mode_i  in  2  privilege mode.
- rec_valid_o  out  1  head record available.
- rec_ready_i  in  1  consumer accepts the head record.
- rec_pc_o  out  32  head record PC.
- rec_insn_o  out  32  head record instruction word.
- rec_rd_addr_o  out  5  head record destination register.
- rec_rd_wdata_o  out  32  head record destination data.
- rec_flags_o  out  4  {intr, trap, mode[1:0]}.
- rec_time_o  out  TimeWidth  head record timestamp.
- count_o  out  $clog2(Depth+1)  occupancy.
- full_o  out  1  count_o == Depth.
- drop_cnt_o  out  DropWidth  dropped/overwritten records, saturating.

## Operation
- match = rvfi_valid_i & cfg_en_i & (!cfg_trap_only_i | rvfi_trap_i | rvfi_intr_i) & (!PcFilterEn | (cfg_pc_lo_i ≤ pc ≤ cfg_pc_hi_i)).
  - The comparison is unsigned.
  - If lo > hi, nothing matches.
- pop = rec_valid_o & rec_ready_i.
- Timestamp counter:
  - Free-running; increments every cycle from 0 after reset.
  - Wraps modulo 2^TimeWidth.
  - Is not cleared by flush_i.
  - A record stores the counter value of its capture cycle.
- Push rules, evaluated against count at the start of the cycle:
  - count < Depth: store the record at the tail.
  - count == Depth, pop this cycle: store; count unchanged.
  - count == Depth, no pop, stop mode: discard the record; drop counter +1.
  - count == Depth, no pop, wrap mode: overwrite the head, advance head and tail; count stays Depth; drop counter +1.
- Head and tail pointers are log2(Depth) bits and wrap naturally. count_o is kept as a separate register.
- Drop counter saturates at all-ones and never wraps.
- flush_i has priority over everything in the same cycle:
  - head, tail and count are set to 0 and the drop counter to 0;
  - a coincident push is neither stored nor counted as a drop;
  - a coincident pop handshake is void.
- Changing cfg_* inputs affects only subsequent cycles; stored records are never re-filtered.
- cfg_en_i = 0 still allows draining.

## Timing
- Reset values: rec_valid_o 0, count_o 0, full_o 0, drop_cnt_o 0, timestamp 0, pointers 0.
- rec_pc_o, rec_insn_o, rec_rd_addr_o, rec_rd_wdata_o, rec_flags_o and rec_time_o read the storage at the head. Their value while empty is don't-care; storage is not reset.
- Capture latency is 1: a record retired in cycle N is visible on rec_* in cycle N+1 if the FIFO was empty.
- rec_valid_o = (count_o != 0), driven from registers; there is no combinational path from rvfi_* to rec_valid_o.
- Handshake: the head record and rec_valid_o hold while rec_ready_i is low, with one exception. In wrap mode, an overwrite while full advances the head, so the presented record changes without a pop; the consumer must tolerate this.
- Throughput: one push and one pop per cycle, sustained.
- An asynchronous reset mid-stream clears all state immediately; there are no partial records.

## Test plan
- **Basic capture.** Depth=4, filters off, retire PCs 0x100, 0x104, 0x108 on consecutive cycles with ready=0.
  - Required: count_o = 3; rec_pc_o = 0x100.
  - Then with ready=1: PCs drain in order, and timestamps differ by 1.
- **Stop-on-full.** Depth=4, cfg_wrap_i=0, 6 retires with ready=0.
  - Required: full_o = 1; records hold PCs 1–4; drop_cnt_o = 2; rec_pc_o still shows record 1.
- **Wrap mode.** Same stimulus with cfg_wrap_i=1.
  - Required: drain yields records 3, 4, 5, 6; drop_cnt_o = 2.
- **Filters.**
  - PC range 0x200–0x2FF with PCs 0x1FC, 0x200, 0x2FF, 0x300: only 0x200 and 0x2FF are stored.
  - cfg_trap_only_i=1: only records with trap or intr set are stored.
  - lo=0x300, hi=0x200: nothing is stored.
- **Simultaneous events.**
  - Full FIFO in stop mode, push and pop in the same cycle: count stays 4, no drop.
  - flush_i coincident with a push: count 0 and drop 0 next cycle.
  - DropWidth=4 with 20 drops: drop_cnt_o saturates at 15.
- **Reset mid-stream.** Assert rst_ni low with 3 records queued.
  - Required: rec_valid_o = 0, count_o = 0, drop_cnt_o = 0 immediately; the timestamp restarts at 0 after release.

Source files
------------

// File: rtl/ibex_rvfi_trace_buf_if.sv
// Drain-side record bus of the RVFI trace buffer.
// valid/ready: a record transfers on a cycle where rec_valid_o and rec_ready_i are both high.
interface ibex_rvfi_trace_buf_if #(
    parameter int unsigned TimeWidth = 16
);
    logic                 rec_valid_o;
    logic                 rec_ready_i;
    logic [31:0]          rec_pc_o;
    logic [31:0]          rec_insn_o;
    logic [4:0]           rec_rd_addr_o;
    logic [31:0]          rec_rd_wdata_o;
    logic [3:0]           rec_flags_o;
    logic [TimeWidth-1:0] rec_time_o;

    modport master (
        output rec_valid_o, rec_pc_o, rec_insn_o, rec_rd_addr_o,
               rec_rd_wdata_o, rec_flags_o, rec_time_o,
        input  rec_ready_i
    );

    modport slave (
        input  rec_valid_o, rec_pc_o, rec_insn_o, rec_rd_addr_o,
               rec_rd_wdata_o, rec_flags_o, rec_time_o,
        output rec_ready_i
    );
endinterface

// File: rtl/ibex_rvfi_trace_buf.sv
// On-chip RVFI trace capture: filters retirements, timestamps them and queues
// them in a circular FIFO (stop-on-full or overwrite-oldest) for a drain agent.
module ibex_rvfi_trace_buf #(
    parameter int unsigned Depth      = 16,
    parameter bit          PcFilterEn = 1'b1,
    parameter int unsigned TimeWidth  = 16,
    parameter int unsigned DropWidth  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cfg_en_i,
    input  logic                       cfg_wrap_i,
    input  logic                       cfg_trap_only_i,
    input  logic [31:0]                cfg_pc_lo_i,
    input  logic [31:0]                cfg_pc_hi_i,
    input  logic                       flush_i,
    input  logic                       rvfi_valid_i,
    input  logic [31:0]                rvfi_pc_rdata_i,
    input  logic [31:0]                rvfi_insn_i,
    input  logic [4:0]                 rvfi_rd_addr_i,
    input  logic [31:0]                rvfi_rd_wdata_i,
    input  logic                       rvfi_trap_i,
    input  logic                       rvfi_intr_i,
    input  logic [1:0]                 rvfi_mode_i,
    ibex_rvfi_trace_buf_if.master      rec,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       full_o,
    output logic [DropWidth-1:0]       drop_cnt_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [CntW-1:0] DepthC = CntW'(Depth);

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          insn;
        logic [4:0]           rd_addr;
        logic [31:0]          rd_wdata;
        logic [3:0]           flags;
        logic [TimeWidth-1:0] ts;
    } rec_t;

    rec_t                 r_mem [Depth];
    logic [PtrW-1:0]      r_head;
    logic [PtrW-1:0]      r_tail;
    logic [CntW-1:0]      r_count;
    logic [DropWidth-1:0] r_drop;
    logic [TimeWidth-1:0] r_time;

    logic w_pc_ok;
    logic w_match;
    logic w_full;
    logic w_pop;
    logic w_store;
    logic w_ovr;
    logic w_drop;
    rec_t w_new;

    // An inverted range (lo > hi) can never satisfy both bounds, so it matches nothing.
    assign w_pc_ok = PcFilterEn ? ((cfg_pc_lo_i <= rvfi_pc_rdata_i) &&
                                   (rvfi_pc_rdata_i <= cfg_pc_hi_i)) : 1'b1;
    assign w_match = rvfi_valid_i & cfg_en_i & w_pc_ok &
                     (~cfg_trap_only_i | rvfi_trap_i | rvfi_intr_i);

    assign w_full  = (r_count == DepthC);
    assign w_pop   = (r_count != '0) & rec.rec_ready_i;
    assign w_store = w_match & (~w_full | w_pop | cfg_wrap_i);
    assign w_ovr   = w_match & w_full & ~w_pop & cfg_wrap_i;
    assign w_drop  = w_match & w_full & ~w_pop;

    assign w_new = '{pc:       rvfi_pc_rdata_i,
                     insn:     rvfi_insn_i,
                     rd_addr:  rvfi_rd_addr_i,
                     rd_wdata: rvfi_rd_wdata_i,
                     flags:    {rvfi_intr_i, rvfi_trap_i, rvfi_mode_i},
                     ts:       r_time};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_drop  <= '0;
            r_time  <= '0;
        end else begin
            r_time <= r_time + TimeWidth'(1);
            if (flush_i) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_drop  <= '0;
            end else begin
                if (w_store) begin
                    r_tail <= r_tail + PtrW'(1);
                end
                // When full, tail == head, so an overwrite replaces the oldest record.
                if (w_pop || w_ovr) begin
                    r_head <= r_head + PtrW'(1);
                end
                r_count <= r_count + CntW'(w_store & ~w_ovr) - CntW'(w_pop);
                if (w_drop && !(&r_drop)) begin
                    r_drop <= r_drop + DropWidth'(1);
                end
            end
        end
    end

    // Record storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (w_store && !flush_i) begin
            r_mem[r_tail] <= w_new;
        end
    end

    assign rec.rec_valid_o    = (r_count != '0);
    assign rec.rec_pc_o       = r_mem[r_head].pc;
    assign rec.rec_insn_o     = r_mem[r_head].insn;
    assign rec.rec_rd_addr_o  = r_mem[r_head].rd_addr;
    assign rec.rec_rd_wdata_o = r_mem[r_head].rd_wdata;
    assign rec.rec_flags_o    = r_mem[r_head].flags;
    assign rec.rec_time_o     = r_mem[r_head].ts;

    assign count_o    = r_count;
    assign full_o     = w_full;
    assign drop_cnt_o = r_drop;

endmodule
